// File: rtl/ft_pkg.sv
// ----------------------------------------------------------------------------
// ft_pkg
// Shared definitions for the fault-tolerance supervisor:
//   - byte offsets of the supervisor register map
//   - CTRL register bit indices
//   - ft_unit_status_t: status bundle reported by one triplicated unit
//   - ft_majority_lost(): true when at least two of three copies are broken
// ----------------------------------------------------------------------------
package ft_pkg;

    // Register map, byte offsets
    localparam int unsigned FTS_CTRL     = 32'h00;
    localparam int unsigned FTS_IRQ      = 32'h04;
    localparam int unsigned FTS_SETBRK   = 32'h08;
    localparam int unsigned FTS_BROKEN   = 32'h0C;
    // Counter block: DET_CNT[u] at base+8u, COR_CNT[u] at base+8u+4
    localparam int unsigned FTS_CNT_BASE = 32'h10;

    // CTRL bit indices
    localparam int unsigned FTS_CTRL_IRQ_EN  = 0;
    localparam int unsigned FTS_CTRL_CLR_ALL = 1;

    typedef struct packed {
        logic       det;
        logic       cor;
        logic [2:0] broken;
    } ft_unit_status_t;

    // Two-of-three vote on the breakage flags of one unit
    function automatic logic ft_majority_lost(input logic [2:0] broken);
        return (broken[0] & broken[1]) | (broken[0] & broken[2]) | (broken[1] & broken[2]);
    endfunction

endpackage

// File: rtl/cv32e40p_ft_sat_counter.sv
// ----------------------------------------------------------------------------
// cv32e40p_ft_sat_counter
// Saturating up-counter used for the per-unit event counts.
// Ports:
//   clk    in   core clock
//   rst_n  in   asynchronous active-low reset
//   inc_i  in   count one event this cycle
//   clr_i  in   clear to zero this cycle (beats inc_i)
//   cnt_o  out  current count, sticks at all-ones
// ----------------------------------------------------------------------------
module cv32e40p_ft_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_ft_supervisor.sv
// ----------------------------------------------------------------------------
// cv32e40p_ft_supervisor
// Collects the FT status of every triplicated unit, counts detected and
// corrected voter mismatches, latches uncorrectable errors and majority loss
// into a W1C status register, drives the forced-broken commands back to the
// units and raises a level interrupt. Registers are reached over a simple
// req/gnt/rvalid slave port with a one-cycle registered response.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   unit_err_detected_i    per-unit voter mismatch
//   unit_err_corrected_i   per-unit mismatch outvoted
//   unit_is_broken_i       per-unit breakage flags, unit u at [3u+2:3u]
//   set_broken_o           forced-broken commands, same packing
//   req_i/we_i/addr_i/wdata_i   register access request
//   gnt_o/rvalid_o/rdata_o      grant and registered response
//   irq_o                  level interrupt
// ----------------------------------------------------------------------------
module cv32e40p_ft_supervisor #(
    parameter int unsigned N_UNITS = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_UNITS-1:0]   unit_err_detected_i,
    input  logic [N_UNITS-1:0]   unit_err_corrected_i,
    input  logic [3*N_UNITS-1:0] unit_is_broken_i,
    output logic [3*N_UNITS-1:0] set_broken_o,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [31:0]          wdata_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 irq_o
);

    import ft_pkg::*;

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned SB_W  = 3 * N_UNITS;
    localparam int unsigned ST_W  = 2 * N_UNITS;

    // Architectural state
    logic              irq_en_q,     irq_en_d;
    logic [ST_W-1:0]   irq_status_q, irq_status_d;
    logic [SB_W-1:0]   set_broken_q, set_broken_d;
    logic [SB_W-1:0]   broken_q,     broken_d;
    logic [N_UNITS-1:0] maj_q,       maj_d;
    logic              irq_q,        irq_d;
    logic              rvalid_q,     rvalid_d;
    logic [31:0]       rdata_q,      rdata_d;

    // Bus decode
    logic [IDX_W-1:0]  idx;
    logic              gnt;
    logic              wr_en;
    logic              rd_en;
    logic              hit_ctrl, hit_irq, hit_setbrk, hit_broken;
    logic [N_UNITS-1:0] det_hit, cor_hit;
    logic              clr_all;
    logic [31:0]       rd_mux;

    // Per-unit event view
    ft_unit_status_t   unit_st [N_UNITS];
    logic [N_UNITS-1:0] maj_now;
    logic [N_UNITS-1:0] unc_set;
    logic [ST_W-1:0]   status_set;
    logic [CNT_W-1:0]  det_cnt [N_UNITS];
    logic [CNT_W-1:0]  cor_cnt [N_UNITS];

    // Byte lanes are implied by word alignment; the low address bits and the
    // unused high write-data bits are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], wdata_i};

    assign idx   = addr_i[ADDR_W-1:2];
    // Only one access in flight: a new request is held off while a response
    // is being presented.
    assign gnt   = req_i & ~rvalid_q;
    assign wr_en = gnt & we_i;
    assign rd_en = gnt & ~we_i;

    assign hit_ctrl   = (idx == IDX_W'(FTS_CTRL >> 2));
    assign hit_irq    = (idx == IDX_W'(FTS_IRQ >> 2));
    assign hit_setbrk = (idx == IDX_W'(FTS_SETBRK >> 2));
    assign hit_broken = (idx == IDX_W'(FTS_BROKEN >> 2));

    assign clr_all = wr_en & hit_ctrl & wdata_i[FTS_CTRL_CLR_ALL];

    generate
        for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unit
            assign unit_st[gi] = {unit_err_detected_i[gi],
                                  unit_err_corrected_i[gi],
                                  unit_is_broken_i[3*gi +: 3]};

            assign maj_now[gi] = ft_majority_lost(unit_st[gi].broken);
            assign unc_set[gi] = unit_st[gi].det & ~unit_st[gi].cor;

            assign det_hit[gi] = (idx == IDX_W'((FTS_CNT_BASE >> 2) + 2 * gi));
            assign cor_hit[gi] = (idx == IDX_W'((FTS_CNT_BASE >> 2) + 2 * gi + 1));

            // Any write to a counter address clears it, whatever the data.
            cv32e40p_ft_sat_counter #(
                .CNT_W (CNT_W)
            ) u_det_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc_i (unit_st[gi].det),
                .clr_i (clr_all | (wr_en & det_hit[gi])),
                .cnt_o (det_cnt[gi])
            );

            cv32e40p_ft_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cor_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc_i (unit_st[gi].cor),
                .clr_i (clr_all | (wr_en & cor_hit[gi])),
                .cnt_o (cor_cnt[gi])
            );
        end
    endgenerate

    // Majority loss is edge-triggered so a unit that stays broken does not
    // re-assert its status bit after software clears it.
    assign status_set = {maj_now & ~maj_q, unc_set};

    // Read mux works on the pre-edge state so a read reports what was there
    // before this cycle's events land.
    always_comb begin
        rd_mux = '0;
        if (hit_ctrl) begin
            rd_mux[FTS_CTRL_IRQ_EN] = irq_en_q;
        end
        if (hit_irq) begin
            rd_mux = 32'(irq_status_q);
        end
        if (hit_setbrk) begin
            rd_mux = 32'(set_broken_q);
        end
        if (hit_broken) begin
            rd_mux = 32'(broken_q);
        end
        for (int u = 0; u < N_UNITS; u++) begin
            if (det_hit[u]) begin
                rd_mux = 32'(det_cnt[u]);
            end
            if (cor_hit[u]) begin
                rd_mux = 32'(cor_cnt[u]);
            end
        end
    end

    always_comb begin
        irq_en_d     = irq_en_q;
        set_broken_d = set_broken_q;
        broken_d     = unit_is_broken_i;
        maj_d        = maj_now;
        irq_d        = irq_en_q & (|irq_status_q);
        rvalid_d     = gnt;
        rdata_d      = '0;

        if (wr_en && hit_ctrl) begin
            irq_en_d = wdata_i[FTS_CTRL_IRQ_EN];
        end
        if (wr_en && hit_setbrk) begin
            set_broken_d = wdata_i[SB_W-1:0];
        end

        // Clears are applied first and new events ORed in afterwards, so a
        // status event arriving in the same cycle as a clear survives.
        irq_status_d = irq_status_q;
        if (wr_en && hit_irq) begin
            irq_status_d = irq_status_d & ~wdata_i[ST_W-1:0];
        end
        if (clr_all) begin
            irq_status_d = '0;
        end
        irq_status_d = irq_status_d | status_set;

        if (rd_en) begin
            rdata_d = rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q     <= 1'b0;
            irq_status_q <= '0;
            set_broken_q <= '0;
            broken_q     <= '0;
            maj_q        <= '0;
            irq_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            irq_en_q     <= irq_en_d;
            irq_status_q <= irq_status_d;
            set_broken_q <= set_broken_d;
            broken_q     <= broken_d;
            maj_q        <= maj_d;
            irq_q        <= irq_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign gnt_o        = gnt;
    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;
    assign irq_o        = irq_q;
    assign set_broken_o = set_broken_q;

endmodule

// File: tb/tb_cv32e40p_ft_supervisor.sv
// ----------------------------------------------------------------------------
// tb_cv32e40p_ft_supervisor
// Directed scenarios plus a randomized run against a cycle-level behavioural
// model built from the register-map rules (integer counts, bit masks,
// $countones for the two-of-three vote).
// ----------------------------------------------------------------------------
module tb_cv32e40p_ft_supervisor;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    det_i = '0;
    logic [N-1:0]    cor_i = '0;
    logic [3*N-1:0]  brk_i = '0;
    logic [3*N-1:0]  set_broken_o;
    logic            req_i = 1'b0;
    logic            we_i = 1'b0;
    logic [AW-1:0]   addr_i = '0;
    logic [31:0]     wdata_i = '0;
    logic            gnt_o;
    logic            rvalid_o;
    logic [31:0]     rdata_o;
    logic            irq_o;

    int total = 0;
    int bad   = 0;

    cv32e40p_ft_supervisor #(
        .N_UNITS (N),
        .CNT_W   (CW),
        .ADDR_W  (AW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .unit_err_detected_i  (det_i),
        .unit_err_corrected_i (cor_i),
        .unit_is_broken_i     (brk_i),
        .set_broken_o         (set_broken_o),
        .req_i                (req_i),
        .we_i                 (we_i),
        .addr_i               (addr_i),
        .wdata_i              (wdata_i),
        .gnt_o                (gnt_o),
        .rvalid_o             (rvalid_o),
        .rdata_o              (rdata_o),
        .irq_o                (irq_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int           m_det [N];
    int           m_cor [N];
    logic [2*N-1:0] m_status;
    logic         m_irq_en;
    logic [3*N-1:0] m_setbrk;
    logic [3*N-1:0] m_brk;
    logic [N-1:0] m_maj;
    logic         m_irq;
    logic         m_rvalid;
    logic [31:0]  m_rdata;

    task automatic model_reset();
        for (int u = 0; u < N; u++) begin
            m_det[u] = 0;
            m_cor[u] = 0;
        end
        m_status = '0; m_irq_en = 1'b0; m_setbrk = '0; m_brk = '0;
        m_maj = '0; m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    endtask

    // Advance one clock: evaluate the model on the current inputs, then let
    // the DUT take the edge and settle.
    task automatic cycle();
        int cmax, widx, u;
        bit gnt, wr, rd, clr_all, lvl;
        logic [31:0] rv;
        int nd [N];
        int nc [N];
        logic [2*N-1:0] st;
        logic [N-1:0] nmaj;
        logic nirq_en, nirq;
        logic [3*N-1:0] nsb;

        cmax = (1 << CW) - 1;
        gnt  = req_i && !m_rvalid;
        widx = int'(addr_i) / 4;
        wr   = gnt && we_i;
        rd   = gnt && !we_i;

        rv = '0;
        if (rd) begin
            if (widx == 0)      rv = {31'b0, m_irq_en};
            else if (widx == 1) rv = 32'(m_status);
            else if (widx == 2) rv = 32'(m_setbrk);
            else if (widx == 3) rv = 32'(m_brk);
            else if (widx < 4 + 2*N) begin
                u  = (widx - 4) / 2;
                rv = ((widx - 4) % 2 == 0) ? m_det[u] : m_cor[u];
            end
        end

        clr_all = wr && (widx == 0) && wdata_i[1];
        nirq_en = (wr && widx == 0) ? wdata_i[0] : m_irq_en;
        nsb     = (wr && widx == 2) ? wdata_i[3*N-1:0] : m_setbrk;
        nirq    = m_irq_en && (m_status != 0);

        st = m_status;
        if (wr && widx == 1) st = st & ~wdata_i[2*N-1:0];
        if (clr_all) st = '0;
        for (int k = 0; k < N; k++) begin
            if (det_i[k] && !cor_i[k]) st[k] = 1'b1;
            lvl = ($countones(brk_i[3*k +: 3]) >= 2);
            if (lvl && !m_maj[k]) st[N+k] = 1'b1;
            nmaj[k] = lvl;
            if (clr_all || (wr && widx == 4 + 2*k))   nd[k] = 0;
            else if (det_i[k] && m_det[k] < cmax)      nd[k] = m_det[k] + 1;
            else                                       nd[k] = m_det[k];
            if (clr_all || (wr && widx == 5 + 2*k))   nc[k] = 0;
            else if (cor_i[k] && m_cor[k] < cmax)      nc[k] = m_cor[k] + 1;
            else                                       nc[k] = m_cor[k];
        end

        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            m_det[k] = nd[k];
            m_cor[k] = nc[k];
        end
        m_status = st; m_irq_en = nirq_en; m_setbrk = nsb; m_brk = brk_i;
        m_maj = nmaj; m_irq = nirq; m_rvalid = gnt; m_rdata = rv;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        det_i = '0; cor_i = '0; brk_i = '0;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One access: grant cycle then an idle cycle; returns the response seen
    // after the grant edge and the model's expected read data.
    task automatic bus_access(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output logic rv, output logic [31:0] exp_rd);
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
        cycle();
        req_i = 1'b0; we_i = 1'b0;
        rv = rvalid_o; rd = rdata_o; exp_rd = m_rdata;
        $display("txn t=%0t we=%0b addr=%02h wdata=%08h rvalid=%0b rdata=%08h", $time, w, a, d, rv, rd);
        cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd, ex;
        logic rv;
        do_reset();
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", rvalid_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq_o); end
        total++; if (set_broken_o !== '0) begin bad++; $display("FAIL reset_setbrk got=%h want=0", set_broken_o); end
        total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata_o); end
        for (int a = 0; a <= 'h2C; a += 4) begin
            req_i = 1'b1; we_i = 1'b0; addr_i = AW'(a);
            #1;
            total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL reset_gnt a=%h got=%b want=1", a, gnt_o); end
            cycle();
            req_i = 1'b0;
            total++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h0) begin
                bad++; $display("FAIL reset_read a=%h rvalid=%b rdata=%h want rvalid=1 rdata=0", a, rvalid_o, rdata_o);
            end
            $display("txn t=%0t we=0 addr=%02h rdata=%08h", $time, a, rdata_o);
            cycle();
            total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid_drop a=%h got=%b want=0", a, rvalid_o); end
        end
        ex = '0; rd = '0; rv = 1'b0;
    endtask

    task automatic test_det_cor();
        logic [31:0] rd, ex;
        logic rv;
        det_i = 4'b0010; cor_i = 4'b0010;
        repeat (5) cycle();
        det_i = '0; cor_i = '0;
        cycle();
        bus_access(1'b0, 8'h18, 0, rd, rv, ex);
        total++; if (rd !== 32'd5 || ex !== 32'd5) begin bad++; $display("FAIL det_cnt1 got=%0d want=5 model=%0d", rd, ex); end
        bus_access(1'b0, 8'h1C, 0, rd, rv, ex);
        total++; if (rd !== 32'd5 || ex !== 32'd5) begin bad++; $display("FAIL cor_cnt1 got=%0d want=5 model=%0d", rd, ex); end
        bus_access(1'b0, 8'h04, 0, rd, rv, ex);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL det_cor_status got=%h want=0", rd); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL det_cor_irq got=%b want=0", irq_o); end
    endtask

    task automatic test_unc_irq();
        logic [31:0] rd, ex;
        logic rv;
        bus_access(1'b1, 8'h00, 32'h1, rd, rv, ex);
        det_i = 4'b0100;
        cycle();
        det_i = '0;
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL unc_irq_early got=%b want=0", irq_o); end
        cycle();
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL unc_irq_raise got=%b want=1", irq_o); end
        bus_access(1'b0, 8'h04, 0, rd, rv, ex);
        total++; if (rd !== 32'h004 || ex !== 32'h004) begin bad++; $display("FAIL unc_status got=%h want=004 model=%h", rd, ex); end
        bus_access(1'b1, 8'h04, 32'h004, rd, rv, ex);
        total++; if (irq_o !== 1'b0 || irq_o !== m_irq) begin bad++; $display("FAIL unc_irq_w1c got=%b want=0", irq_o); end
    endtask

    task automatic test_majority();
        logic [31:0] rd, ex;
        logic rv;
        brk_i[2:0] = 3'b001; cycle();
        brk_i[2:0] = 3'b011; cycle();
        bus_access(1'b0, 8'h04, 0, rd, rv, ex);
        total++; if (rd !== 32'h010 || ex !== 32'h010) begin bad++; $display("FAIL maj_status got=%h want=010 model=%h", rd, ex); end
        bus_access(1'b0, 8'h0C, 0, rd, rv, ex);
        total++; if (rd !== 32'h003) begin bad++; $display("FAIL maj_broken got=%h want=003", rd); end
        bus_access(1'b1, 8'h04, 32'h010, rd, rv, ex);
        brk_i[2:0] = 3'b111;
        repeat (4) cycle();
        bus_access(1'b0, 8'h04, 0, rd, rv, ex);
        total++; if (rd !== 32'h0 || ex !== 32'h0) begin bad++; $display("FAIL maj_held got=%h want=0 model=%h", rd, ex); end
        brk_i = '0;
        cycle();
    endtask

    task automatic test_saturation();
        logic [31:0] rd, ex;
        logic rv;
        det_i = 4'b1000; cor_i = 4'b1000;
        repeat (20) cycle();
        bus_access(1'b0, 8'h28, 0, rd, rv, ex);
        total++; if (rd !== 32'd15 || ex !== 32'd15) begin bad++; $display("FAIL sat_det got=%0d want=15 model=%0d", rd, ex); end
        // write lands in the same cycle as a det pulse: the clear must win
        req_i = 1'b1; we_i = 1'b1; addr_i = 8'h28; wdata_i = 32'hDEAD;
        cycle();
        req_i = 1'b0; we_i = 1'b0; det_i = '0; cor_i = '0;
        cycle();
        bus_access(1'b0, 8'h28, 0, rd, rv, ex);
        total++; if (rd !== 32'd0 || ex !== 32'd0) begin bad++; $display("FAIL sat_clr got=%0d want=0 model=%0d", rd, ex); end
        bus_access(1'b0, 8'h2C, 0, rd, rv, ex);
        total++; if (rd !== 32'd15) begin bad++; $display("FAIL sat_cor got=%0d want=15", rd); end
    endtask

    task automatic test_clr_all();
        logic [31:0] rd, ex;
        logic rv;
        det_i = 4'b0001; cycle(); det_i = '0; cycle();
        bus_access(1'b1, 8'h00, 32'h3, rd, rv, ex);
        bus_access(1'b0, 8'h00, 0, rd, rv, ex);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL clr_ctrl_read got=%h want=1", rd); end
        bus_access(1'b0, 8'h10, 0, rd, rv, ex);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL clr_det0 got=%h want=0", rd); end
        bus_access(1'b0, 8'h04, 0, rd, rv, ex);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL clr_status got=%h want=0", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, ex, d;
        logic rv, w;
        logic [AW-1:0] a;
        for (int it = 0; it < 200; it++) begin
            det_i = N'($urandom); cor_i = N'($urandom);
            if ($urandom_range(0, 3) == 0) brk_i = (3*N)'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                a = AW'($urandom_range(0, 13) * 4);
                w = ($urandom_range(0, 3) == 0);
                d = $urandom;
                if (a == 8'h00) d[1] = 1'b0;
                bus_access(w, a, d, rd, rv, ex);
                total++; if (rv !== 1'b1 || rd !== ex) begin
                    bad++; $display("FAIL rand_bus it=%0d addr=%h we=%b rvalid=%b rdata=%h want=%h", it, a, w, rv, rd, ex);
                end
            end else begin
                cycle();
            end
            total++; if (irq_o !== m_irq || set_broken_o !== m_setbrk) begin
                bad++; $display("FAIL rand_out it=%0d irq=%b/%b setbrk=%h/%h", it, irq_o, m_irq, set_broken_o, m_setbrk);
            end
        end
        det_i = '0; cor_i = '0; brk_i = '0;
        cycle();
    endtask

    task automatic test_set_broken_reset();
        logic [31:0] rd, ex;
        logic rv;
        req_i = 1'b1; we_i = 1'b1; addr_i = 8'h08; wdata_i = 32'hFFFF_FA05;
        cycle();
        req_i = 1'b0; we_i = 1'b0;
        total++; if (set_broken_o !== 12'hA05) begin bad++; $display("FAIL setbrk_drive got=%h want=a05", set_broken_o); end
        cycle();
        bus_access(1'b0, 8'h08, 0, rd, rv, ex);
        total++; if (rd !== 32'h0000_0A05 || ex !== 32'h0000_0A05) begin bad++; $display("FAIL setbrk_read got=%h want=a05", rd); end
        // read in flight, then reset before the response is consumed
        req_i = 1'b1; addr_i = 8'h08;
        cycle();
        req_i = 1'b0;
        total++; if (rvalid_o !== 1'b1) begin bad++; $display("FAIL rst_pre_rvalid got=%b want=1", rvalid_o); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", rvalid_o); end
        total++; if (set_broken_o !== '0) begin bad++; $display("FAIL rst_setbrk got=%h want=0", set_broken_o); end
        do_reset();
        cycle();
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL rst_after_rvalid got=%b want=0", rvalid_o); end
    endtask

    initial begin
        test_reset();
        test_det_cor();
        test_unc_irq();
        test_majority();
        test_saturation();
        test_clr_all();
        test_random();
        test_set_broken_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
